// File: rtl/lpc_pkg.sv
// Shared constants and types for the LPC frame controller.
// Register map, CTRL/STATUS bit layout and the frame-length clamp helper.
package lpc_pkg;

   localparam int LPC_ORDER         = 10;
   localparam int FRAME_LEN_DEFAULT = 240;
   localparam int LEN_W             = 10;

   localparam logic [3:0] REG_FRAME_LEN = 4'h0;
   localparam logic [3:0] REG_CTRL      = 4'h1;
   localparam logic [3:0] REG_STATUS    = 4'h2;
   localparam logic [3:0] REG_FRAME_CNT = 4'h3;
   localparam logic [3:0] REG_FREQ      = 4'h4;
   localparam logic [3:0] REG_A0        = 4'h5;
   localparam logic [3:0] REG_A10       = 4'hF;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_SOFT_CLR = 2;

   localparam int ST_BUSY    = 0;
   localparam int ST_READY   = 1;
   localparam int ST_OVERRUN = 2;
   localparam int ST_VOICED  = 3;

   typedef struct packed {
      logic [11:0] rsvd;
      logic        voiced;
      logic        overrun;
      logic        ready;
      logic        busy;
   } status_t;

   typedef enum logic {
      CALC_IDLE = 1'b0,
      CALC_RUN  = 1'b1
   } calc_state_t;

   function automatic logic [LEN_W-1:0] clamp_len(
      input logic [15:0] d,
      input int          lo,
      input int          hi
   );
      int dv;
      dv = int'(d);
      if (dv < lo) return LEN_W'(lo);
      if (dv > hi) return LEN_W'(hi);
      return d[LEN_W-1:0];
   endfunction

endpackage

// File: rtl/lpc_frame_ctrl_if.sv
// Register access port of the LPC frame controller.
// Read data is registered and valid the cycle after read.
interface lpc_frame_ctrl_if;
   logic [15:0] address;
   logic        read;
   logic        write;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address, read, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata
   );
endinterface

// File: rtl/lpc_tick_sync.sv
// Brings the asynchronous d_clk into the clk domain and
// emits a single-cycle tick on each rising edge.
module lpc_tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_clk,
   output logic tick
);

   logic [2:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[1:0], d_clk};
   end

   // sr[1] is the second synchronizer stage, sr[2] its history
   assign tick = sr[1] & ~sr[2];

endmodule

// File: rtl/lpc_frame_ctrl.sv
// Frame sequencer and register front-end for the LPC encoder:
// sample strobes, frame counting, calc handshake, register file.
module lpc_frame_ctrl
   import lpc_pkg::*;
#(
   parameter int DW        = 16,
   parameter int ORDER     = 10,
   parameter int FRAME_MAX = 512,
   parameter int FRAME_MIN = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      d_clk,
   input  logic signed [DW-1:0]      x,
   input  logic                      v,
   lpc_frame_ctrl_if.slave           bus,
   output logic                      smp_valid,
   output logic [DW-1:0]             smp_data,
   output logic                      frame_start,
   output logic                      frame_end,
   output logic                      calc_start,
   input  logic                      calc_done,
   input  logic [(ORDER+1)*DW-1:0]   coef_in,
   input  logic                      voiced_in,
   input  logic [15:0]               freq_in,
   output logic                      frame_irq
);

   logic                   tick;
   logic [3:0]             addr;
   logic                   wr_len, wr_ctrl, rd_status, soft_clr;
   logic [LEN_W-1:0]       frame_len, len_active, idx;
   logic                   last;
   logic                   en, irq_en;
   logic                   ready, overrun, voiced;
   logic [15:0]            frame_cnt, freq;
   logic [(ORDER+1)*DW-1:0] coef;
   calc_state_t            state, state_nxt;
   logic                   start_nxt, done_acc, ov_set;
   status_t                st;
   logic [3:0]             ai;
   logic [15:0]            rd_mux;
   logic                   unused;

   lpc_tick_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_clk (d_clk),
      .tick  (tick)
   );

   assign addr      = bus.address[3:0];
   assign unused    = ^bus.address[15:4];
   assign wr_len    = bus.write && addr == REG_FRAME_LEN;
   assign wr_ctrl   = bus.write && addr == REG_CTRL;
   assign rd_status = bus.read && addr == REG_STATUS;
   assign soft_clr  = wr_ctrl && bus.writedata[CTRL_SOFT_CLR];
   assign last      = idx == len_active - LEN_W'(1);
   assign frame_irq = ready & irq_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_valid   <= 1'b0;
         smp_data    <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         idx         <= '0;
         len_active  <= LEN_W'(FRAME_LEN_DEFAULT);
      end else begin
         smp_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         if (soft_clr || !en) begin
            idx <= '0;
         end else if (tick && v) begin
            smp_valid   <= 1'b1;
            smp_data    <= x;
            frame_start <= idx == '0;
            frame_end   <= last;
            idx         <= last ? '0 : idx + LEN_W'(1);
            // new length only applies from the next frame on
            if (last) len_active <= frame_len;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CALC_IDLE;
         calc_start <= 1'b0;
      end else begin
         state      <= state_nxt;
         calc_start <= start_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_nxt = 1'b0;
      done_acc  = 1'b0;
      ov_set    = 1'b0;
      unique case (state)
         CALC_IDLE: begin
            if (frame_end) begin
               state_nxt = CALC_RUN;
               start_nxt = 1'b1;
            end
         end
         CALC_RUN: begin
            if (calc_done) begin
               done_acc = 1'b1;
               if (frame_end) start_nxt = 1'b1;
               else           state_nxt = CALC_IDLE;
            end else if (frame_end) begin
               ov_set = 1'b1;
            end
         end
      endcase
      if (soft_clr) begin
         state_nxt = CALC_IDLE;
         start_nxt = 1'b0;
         done_acc  = 1'b0;
         ov_set    = 1'b0;
      end
   end

   always_comb begin
      st         = '0;
      st.busy    = state == CALC_RUN;
      st.ready   = ready;
      st.overrun = overrun;
      st.voiced  = voiced;
   end

   always_comb begin
      rd_mux = '0;
      ai     = addr - REG_A0;
      unique case (1'b1)
         addr == REG_FRAME_LEN: rd_mux = 16'(frame_len);
         addr == REG_CTRL:      rd_mux = {14'd0, irq_en, en};
         addr == REG_STATUS:    rd_mux = st;
         addr == REG_FRAME_CNT: rd_mux = frame_cnt;
         addr == REG_FREQ:      rd_mux = freq;
         addr >= REG_A0:        rd_mux = 16'($signed(coef[ai*DW +: DW]));
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_len    <= LEN_W'(FRAME_LEN_DEFAULT);
         en           <= 1'b0;
         irq_en       <= 1'b0;
         ready        <= 1'b0;
         overrun      <= 1'b0;
         voiced       <= 1'b0;
         frame_cnt    <= '0;
         freq         <= '0;
         coef         <= '0;
         bus.readdata <= '0;
      end else begin
         if (wr_len)
            frame_len <= clamp_len(bus.writedata, FRAME_MIN, FRAME_MAX);
         if (wr_ctrl && !bus.writedata[CTRL_SOFT_CLR]) begin
            en     <= bus.writedata[CTRL_EN];
            irq_en <= bus.writedata[CTRL_IRQ_EN];
         end
         if (rd_status) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
         end
         if (ov_set) overrun <= 1'b1;
         if (done_acc) begin
            ready     <= 1'b1;
            voiced    <= voiced_in;
            freq      <= freq_in;
            coef      <= coef_in;
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (soft_clr) begin
            ready     <= 1'b0;
            overrun   <= 1'b0;
            voiced    <= 1'b0;
            frame_cnt <= '0;
            freq      <= '0;
            coef      <= '0;
         end
         if (bus.read) bus.readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Scoreboard bench for lpc_frame_ctrl: stimulus queues expected
// samples and read data, a negedge monitor pops and compares.
module tb_lpc_frame_ctrl;
   import lpc_pkg::*;

   localparam int DW    = 16;
   localparam int ORDER = 10;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    d_clk = 1'b0;
   logic                    v = 1'b0;
   logic signed [DW-1:0]    x = '0;
   logic                    calc_done = 1'b0;
   logic                    voiced_in = 1'b0;
   logic [(ORDER+1)*DW-1:0] coef_in = '0;
   logic [15:0]             freq_in = '0;
   logic                    smp_valid, frame_start, frame_end;
   logic                    calc_start, frame_irq;
   logic [DW-1:0]           smp_data;

   lpc_frame_ctrl_if bus();

   lpc_frame_ctrl #(
      .DW(DW), .ORDER(ORDER), .FRAME_MAX(512), .FRAME_MIN(16)
   ) dut (
      .clk(clk), .rst(rst), .d_clk(d_clk), .x(x), .v(v),
      .bus(bus),
      .smp_valid(smp_valid), .smp_data(smp_data),
      .frame_start(frame_start), .frame_end(frame_end),
      .calc_start(calc_start), .calc_done(calc_done),
      .coef_in(coef_in), .voiced_in(voiced_in), .freq_in(freq_in),
      .frame_irq(frame_irq)
   );

   always #10 clk = ~clk;

   typedef struct {
      int data;
      bit fs;
      bit fe;
      int rise;
   } smp_t;

   smp_t smp_q[$];
   int   rd_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   cs_cnt = 0;
   bit   rd_seen = 1'b0;
   bit   fe_prev = 1'b0;
   int   m_idx = 0;
   int   m_len = 240;
   int   m_flen = 240;
   bit   m_en = 1'b0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   task automatic fail_now(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_seen <= bus.read;
   end

   always @(negedge clk) begin
      if (rd_seen) begin
         if (rd_q.size() == 0) fail_now("readdata_extra");
         else chk("readdata", int'(bus.readdata), rd_q.pop_front());
      end
      if (smp_valid) begin
         if (smp_q.size() == 0) begin
            fail_now("smp_valid_extra");
         end else begin
            smp_t e;
            e = smp_q.pop_front();
            chk("smp_data", int'($signed(smp_data)), e.data);
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("frame_end", int'(frame_end), int'(e.fe));
            chk("smp_latency", cyc - e.rise, 3);
         end
      end else if (frame_start || frame_end) begin
         fail_now("frame_flag_without_strobe");
      end
      if (calc_start) begin
         cs_cnt++;
         chk("calc_start_after_fe", int'(fe_prev), 1);
      end
      fe_prev = frame_end;
   end

   task automatic wr(logic [3:0] a, logic [15:0] d);
      @(negedge clk);
      bus.address   = {12'd0, a};
      bus.writedata = d;
      bus.write     = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic rd(logic [3:0] a, int exp);
      @(negedge clk);
      rd_q.push_back(exp);
      bus.address = {12'd0, a};
      bus.read    = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
   endtask

   task automatic wrrd(logic [3:0] a, logic [15:0] d, int exp);
      @(negedge clk);
      rd_q.push_back(exp);
      bus.address   = {12'd0, a};
      bus.writedata = d;
      bus.write     = 1'b1;
      bus.read      = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
      bus.read  = 1'b0;
   endtask

   task automatic rd_done(logic [3:0] a, int exp);
      @(negedge clk);
      rd_q.push_back(exp);
      bus.address = {12'd0, a};
      bus.read    = 1'b1;
      calc_done   = 1'b1;
      @(negedge clk);
      bus.read  = 1'b0;
      calc_done = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
   endtask

   task automatic sample(int xv, bit vv, bit coll);
      smp_t e;
      @(negedge clk);
      x     = DW'(xv);
      v     = vv;
      d_clk = 1'b1;
      if (vv && m_en) begin
         e.data = xv;
         e.fs   = m_idx == 0;
         e.fe   = m_idx == m_len - 1;
         e.rise = cyc;
         smp_q.push_back(e);
         if (e.fe) begin
            m_idx = 0;
            m_len = m_flen;
         end else begin
            m_idx++;
         end
      end
      repeat (3) @(negedge clk);
      if (coll) calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      d_clk     = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic feed(int n, int base);
      for (int i = 0; i < n; i++) sample(base + i, 1'b1, 1'b0);
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_smp_valid"}, int'(smp_valid), 0);
      chk({tag, "_smp_data"}, int'(smp_data), 0);
      chk({tag, "_frame_start"}, int'(frame_start), 0);
      chk({tag, "_frame_end"}, int'(frame_end), 0);
      chk({tag, "_calc_start"}, int'(calc_start), 0);
      chk({tag, "_frame_irq"}, int'(frame_irq), 0);
      chk({tag, "_readdata"}, int'(bus.readdata), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.address   = '0;
      bus.writedata = '0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      rd(REG_FRAME_LEN, 240);
      rd(REG_CTRL, 0);
      rd(REG_STATUS, 0);

      // basic frame of 240 and coefficient readback
      wr(REG_FRAME_LEN, 16'd240);
      wr(REG_CTRL, 16'h3);
      m_en = 1'b1;
      feed(240, -100);
      chk("cs_cnt_t1", cs_cnt, 1);
      repeat (100) @(negedge clk);
      for (int k = 0; k <= ORDER; k++)
         coef_in[k*DW +: DW] = DW'(16'h1000 + k);
      voiced_in = 1'b1;
      freq_in   = 16'd57;
      pulse_done();
      @(negedge clk);
      chk("frame_irq_set", int'(frame_irq), 1);
      rd(REG_STATUS, 'h000A);
      rd(REG_FRAME_CNT, 1);
      rd(REG_FREQ, 57);
      for (int k = 0; k <= ORDER; k++)
         rd(REG_A0 + 4'(k), 'h1000 + k);
      rd(REG_STATUS, 'h0008);
      @(negedge clk);
      chk("frame_irq_clr", int'(frame_irq), 0);

      // latency and v=0 hold
      sample(-1234, 1'b1, 1'b0);
      sample(777, 1'b0, 1'b0);
      sample(55, 1'b1, 1'b0);

      // soft clear
      wr(REG_CTRL, 16'h7);
      m_idx = 0;
      rd(REG_CTRL, 3);
      rd(REG_STATUS, 0);
      rd(REG_FRAME_CNT, 0);
      rd(REG_FREQ, 0);
      rd(REG_A0, 0);

      // mid-frame length update and clamping
      voiced_in = 1'b0;
      feed(50, 1000);
      wr(REG_FRAME_LEN, 16'd100);
      m_flen = 100;
      rd(REG_FRAME_LEN, 100);
      feed(190, 2000);
      chk("cs_cnt_t4a", cs_cnt, 2);
      pulse_done();
      rd(REG_STATUS, 'h0002);
      wr(REG_FRAME_LEN, 16'd5);
      rd(REG_FRAME_LEN, 16);
      wr(REG_FRAME_LEN, 16'd1000);
      rd(REG_FRAME_LEN, 512);
      wrrd(REG_FRAME_LEN, 16'd100, 512);
      rd(REG_FRAME_LEN, 100);
      feed(10, 3000);
      wr(REG_FRAME_LEN, 16'd16);
      m_flen = 16;
      feed(90, 3100);
      chk("cs_cnt_t4b", cs_cnt, 3);
      pulse_done();
      rd(REG_STATUS, 'h0002);
      rd(REG_FRAME_CNT, 2);

      // overrun with calc_done held low
      feed(16, 4000);
      chk("cs_cnt_t3a", cs_cnt, 4);
      feed(16, 4100);
      chk("cs_cnt_t3b", cs_cnt, 4);
      rd(REG_STATUS, 'h0005);
      feed(16, 4200);
      chk("cs_cnt_t3c", cs_cnt, 4);
      pulse_done();
      rd(REG_STATUS, 'h0006);
      rd(REG_STATUS, 'h0000);
      rd(REG_FRAME_CNT, 3);

      // frame_end and calc_done in the same cycle
      feed(16, 5000);
      chk("cs_cnt_t5a", cs_cnt, 5);
      feed(15, 5100);
      sample(5115, 1'b1, 1'b1);
      chk("cs_cnt_t5b", cs_cnt, 6);
      rd(REG_STATUS, 'h0003);
      rd(REG_FRAME_CNT, 4);

      // STATUS read collides with ready set
      rd_done(REG_STATUS, 'h0001);
      rd(REG_STATUS, 'h0002);
      rd(REG_FRAME_CNT, 5);

      // enable dropped while a calc is pending
      feed(16, 6000);
      chk("cs_cnt_t6a", cs_cnt, 7);
      wr(REG_CTRL, 16'h2);
      m_en  = 1'b0;
      m_idx = 0;
      sample(9, 1'b1, 1'b0);

      // reset during RUN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      m_idx  = 0;
      m_len  = 240;
      m_flen = 240;
      chk_reset_outputs("rst_run");
      pulse_done();
      rd(REG_FRAME_CNT, 0);
      rd(REG_FRAME_LEN, 240);
      rd(REG_STATUS, 0);
      rd(REG_CTRL, 0);
      repeat (5) @(negedge clk);
      chk("cs_cnt_end", cs_cnt, 7);
      chk("rd_q_left", rd_q.size(), 0);
      chk("smp_q_left", smp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
